// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: register-field widths, forward-select
// encodings and the memory-wait FSM state used by the hazard controller.
package hazard_ctrl_pkg;
  localparam int REGS_WIDTH = 5;
  localparam int NUM_REGS   = 1 << REGS_WIDTH;
  localparam int FW_WIDTH   = 2;

  typedef enum logic [FW_WIDTH-1:0] {
    FW_NONE  = 2'd0,
    FW_EXMEM = 2'd1,
    FW_MEMWB = 2'd2
  } fw_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_MERR  = 2'd2
  } mem_state_e;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REGS_WIDTH-1:0] r);
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard bundle: ID/EX register fields, mul/div and memory
// handshakes in; stall/flush/freeze controls and scoreboard state out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REGS_WIDTH-1:0] IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
  logic                  IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_RegWrite, IF_ID_is_md;
  logic [REGS_WIDTH-1:0] ID_EX_rd;
  logic                  ID_EX_MemRead, ID_EX_is_md;
  logic                  md_start, md_done;
  logic [REGS_WIDTH-1:0] md_rd;
  logic                  br_taken, mem_req, mem_ready;

  logic                  stall_front, bubble_ex, freeze;
  logic                  flush_if_id, flush_id_ex;
  logic                  md_busy, mem_err;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use_rs1, IF_ID_use_rs2,
           IF_ID_RegWrite, IF_ID_is_md, ID_EX_rd, ID_EX_MemRead, ID_EX_is_md,
           md_start, md_rd, md_done, br_taken, mem_req, mem_ready,
    input  stall_front, bubble_ex, freeze, flush_if_id, flush_id_ex,
           md_busy, busy_mask, mem_err
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use_rs1, IF_ID_use_rs2,
           IF_ID_RegWrite, IF_ID_is_md, ID_EX_rd, ID_EX_MemRead, ID_EX_is_md,
           md_start, md_rd, md_done, br_taken, mem_req, mem_ready,
    output stall_front, bubble_ex, freeze, flush_if_id, flush_id_ex,
           md_busy, busy_mask, mem_err
  );
endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Busy-register scoreboard for the single outstanding mul/div operation.
// eff_busy_o already drops the register being written back this cycle.
module hazard_ctrl_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  md_start_i,
  input  logic [REGS_WIDTH-1:0] md_rd_i,
  input  logic                  md_done_i,
  output logic [NUM_REGS-1:0]   busy_mask_o,
  output logic [NUM_REGS-1:0]   eff_busy_o,
  output logic                  md_busy_o
);
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic [REGS_WIDTH-1:0] pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic                  done_eff;

  // Clear of the retiring rd is applied before the new set, so a same-rd
  // restart keeps its bit.
  always_comb begin
    done_eff   = md_done_i & busy_q;
    eff_busy_o = mask_q & ~(done_eff ? onehot(pend_q) : '0);
    mask_d     = eff_busy_o;
    pend_d     = pend_q;
    busy_d     = busy_q & ~done_eff;
    if (md_start_i && md_rd_i != '0) begin
      mask_d = eff_busy_o | onehot(md_rd_i);
      pend_d = md_rd_i;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign busy_mask_o = mask_q;
  assign md_busy_o   = busy_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze controller: data-hazard compare against EX and the
// mul/div scoreboard, memory-wait FSM with timeout, and output priority.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [NUM_REGS-1:0] eff_busy, busy_mask;
  logic                md_busy;

  hazard_ctrl_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .md_start_i  (hz.md_start),
    .md_rd_i     (hz.md_rd),
    .md_done_i   (hz.md_done),
    .busy_mask_o (busy_mask),
    .eff_busy_o  (eff_busy),
    .md_busy_o   (md_busy)
  );

  logic long_ex, rs1_hit, rs2_hit, waw, structural, dstall;

  always_comb begin
    long_ex    = (hz.ID_EX_MemRead | hz.ID_EX_is_md) & (hz.ID_EX_rd != '0);
    rs1_hit    = hz.IF_ID_use_rs1 & (hz.IF_ID_rs1 != '0) &
                 ((long_ex & (hz.ID_EX_rd == hz.IF_ID_rs1)) | eff_busy[hz.IF_ID_rs1]);
    rs2_hit    = hz.IF_ID_use_rs2 & (hz.IF_ID_rs2 != '0) &
                 ((long_ex & (hz.ID_EX_rd == hz.IF_ID_rs2)) | eff_busy[hz.IF_ID_rs2]);
    waw        = hz.IF_ID_RegWrite & (hz.IF_ID_rd != '0) & eff_busy[hz.IF_ID_rd];
    structural = hz.IF_ID_is_md & ((md_busy & ~hz.md_done) | hz.ID_EX_is_md);
    dstall     = rs1_hit | rs2_hit | waw | structural;
  end

  mem_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_err_q;

  // cnt_q counts wait cycles already spent; MERR is entered once the
  // MEM_TIMEOUT-th consecutive wait cycle passes without mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: if (hz.mem_req && !hz.mem_ready) begin
          cnt_q <= CW'(1);
          if (MEM_TIMEOUT <= 1) begin
            state_q   <= ST_MERR;
            mem_err_q <= 1'b1;
          end else begin
            state_q <= ST_MWAIT;
          end
        end
        ST_MWAIT: if (hz.mem_ready) begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(MEM_TIMEOUT)) begin
            state_q   <= ST_MERR;
            mem_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic freeze;
  assign freeze = ((state_q == ST_RUN) & hz.mem_req & ~hz.mem_ready) |
                  ((state_q == ST_MWAIT) & ~hz.mem_ready) |
                  (state_q == ST_MERR);

  assign hz.freeze      = freeze;
  assign hz.flush_if_id = ~freeze & hz.br_taken;
  assign hz.flush_id_ex = ~freeze & hz.br_taken;
  assign hz.stall_front = ~freeze & ~hz.br_taken & dstall;
  assign hz.bubble_ex   = ~freeze & ~hz.br_taken & dstall;
  assign hz.md_busy     = md_busy;
  assign hz.busy_mask   = busy_mask;
  assign hz.mem_err     = mem_err_q;
endmodule
